alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares the single registered ALU among `N_CORES` requesters (cores). It sits between the per-core execute stages and the ALU instance. It accepts one operation at a time, drives the ALU operand/opcode inputs, captures the registered result, and returns it with a one-hot completion pulse. It computes its own zero flag and screens illegal ops and divide/modulo by zero before they reach the ALU.

## Interface
- `N_CORES`, 4: number of requesters (≥2).
- `DATA_W`, 16: operand/result width.
- `i_clk` in 1: clock; everything is on the rising edge.
- `i_rst` in 1: synchronous reset, active-high.
- `i_req` in N_CORES: per-core request level. Held until that core's `o_done`.
- `i_op` in 3·N_CORES: per-core opcode, core k at bits [3k+2:3k]. 1=add, 2=sub (in2−in1), 3=mul, 4=div (in2/in1), 5=mod (in2%in1).
- `i_in1`, `i_in2` in DATA_W·N_CORES: per-core operands, core k at [DATA_W·k +: DATA_W].
- `o_gnt` out N_CORES: one-hot grant pulse, one cycle long.
- `o_done` out N_CORES: one-hot completion pulse, one cycle long.
- `o_result` out DATA_W: result, valid while `o_done` is high and held until the next completion.
- `o_z` out 1: `o_result == 0`, valid with `o_done`.
- `o_err` out 1: illegal op or division by zero, valid with `o_done`.
- `o_alu_op` out 3, `o_alu_in1` out DATA_W, `o_alu_in2` out DATA_W: drive the ALU inputs.
- `i_alu_out` in DATA_W: ALU registered result.

## Operation
- FSM states: IDLE → ISSUE → WAIT → DONE → IDLE. Each state lasts exactly one cycle, except IDLE, which lasts until any `i_req` bit is set.
- **Arbitration (IDLE)**
  - Priority is round-robin, starting at `last_gnt+1` modulo N_CORES.
  - `last_gnt` resets to N_CORES−1, so core 0 wins first.
  - The winner's op and operands are latched at the grant edge and are not sampled again afterwards.
- **Screening at grant**
  - Ops 0, 6 and 7 are illegal.
  - Op 4 or 5 with `in1 == 0` is division by zero.
  - Either case sets the internal err flag and drives `o_alu_op = 0`, so the ALU holds its value and is never given /0.
- **ISSUE**: `o_alu_op`/`o_alu_in1`/`o_alu_in2` present the latched values. `o_gnt` is high.
- **WAIT**: `o_alu_op` returns to 0. At the end of WAIT:
  - `o_result` ← `i_alu_out`, or 0 if err.
  - `o_z` ← (result == 0) && !err.
  - `o_err` ← err.
  - `o_done` ← onehot(winner).
- **DONE**: `o_done` is high for this one cycle. `o_done` clears at the end of DONE and the FSM returns to IDLE.
- **Arithmetic**: the arbiter does no arithmetic.
  - Results are the ALU's DATA_W-bit truncated values.
  - Sub wraps modulo 2^DATA_W, e.g. in2=1, in1=2 → 0xFFFF.
  - Mul keeps the low DATA_W bits.
- The ALU zero output is not used; it lags by one result.
- **Request dropped after grant**: the operation still completes and `o_done` still pulses.
- **Request dropped before grant**: that core is simply not considered.
- **Reset mid-operation**: the FSM returns to IDLE and the in-flight op is abandoned with no `o_done`. All outputs go to 0 and `last_gnt` goes to N_CORES−1.

## Timing
- All outputs are registered.
- Reset values: `o_gnt=0`, `o_done=0`, `o_result=0`, `o_z=0`, `o_err=0`, `o_alu_op=0`, `o_alu_in1=0`, `o_alu_in2=0`.
- Cycle timeline:
  - Edge E0: IDLE with a request → grant decided.
  - Cycle after E0: `o_gnt` high, ALU inputs valid.
  - Edge E1: ALU registers its result.
  - Edge E2: result captured.
  - Cycle after E2: `o_done` high.
  - Edge E3: back to IDLE.
- The next grant is no earlier than E4, so there is one operation per 4 cycles.
- Request to `o_done` latency is 3 cycles when the arbiter is idle. The same latency applies to error cases.
- Starvation bound: a held request completes within N_CORES·4 + 3 cycles.

## Test plan
- **Reset**: assert `i_rst` 2 cycles → all outputs 0. Core 0 add 3+4 → `o_gnt`=0001 at cycle 1; `o_done`=0001 with `o_result`=7, `o_z`=0 at cycle 3.
- **Round-robin**: all four cores hold requests → grant order 0,1,2,3,0 with grants exactly 4 cycles apart. Core 2 sub in1=5, in2=5 → `o_result`=0, `o_z`=1.
- **Wrap and truncate**: sub in1=2, in2=1 → 0xFFFF. Mul 0x0100·0x0100 → 0x0000 with `o_z`=1. Div in2=17, in1=5 → 3. Mod → 2.
- **Screening**: div with in1=0 → `o_alu_op` stays 0 throughout, `o_err`=1, `o_result`=0, `o_z`=0, latency 3. Op 7 → same response.
- **Mid-operation events**:
  - Core 1 drops `i_req` in WAIT → `o_done`=0010 still pulses.
  - `i_rst` during WAIT → no `o_done`. The next request from core 3 with core 0 also requesting grants core 0.
- **Operand stability**: change core 0's `i_in1` the cycle after grant → `o_result` reflects the operands latched at grant.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one registered ALU among N_CORES cores
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req[N]                      per-core request level, held until that core's o_done
//   i_op[3N], i_in1/i_in2[W*N]    per-core opcode and operands
//   o_gnt[N], o_done[N]           one-hot grant / completion pulses
//   o_result, o_z, o_err          completion result, zero flag, error flag
//   o_alu_op, o_alu_in1/in2       drive the shared ALU
//   i_alu_out                     registered ALU result
module alu_arbiter #(
    parameter int N_CORES = 4,
    parameter int DATA_W  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_CORES-1:0]        i_req,
    input  logic [3*N_CORES-1:0]      i_op,
    input  logic [DATA_W*N_CORES-1:0] i_in1,
    input  logic [DATA_W*N_CORES-1:0] i_in2,
    output logic [N_CORES-1:0]        o_gnt,
    output logic [N_CORES-1:0]        o_done,
    output logic [DATA_W-1:0]         o_result,
    output logic                      o_z,
    output logic                      o_err,
    output logic [2:0]                o_alu_op,
    output logic [DATA_W-1:0]         o_alu_in1,
    output logic [DATA_W-1:0]         o_alu_in2,
    input  logic [DATA_W-1:0]         i_alu_out
);
    localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [N_CORES-1:0] ONE = {{(N_CORES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_next;
    logic [IW-1:0]     last_gnt, win, win_q;
    logic              any_req, bad, err_q;
    logic [2:0]        sel_op;
    logic [DATA_W-1:0] sel_in1, sel_in2;

    // Walk candidates from farthest to nearest after last_gnt so the nearest requester wins.
    always_comb begin
        win     = last_gnt;
        any_req = 1'b0;
        for (int i = N_CORES; i >= 1; i--) begin
            int c;
            c = int'(last_gnt) + i;
            c = (c >= N_CORES) ? c - N_CORES : c;
            if (i_req[c]) begin
                win     = IW'(c);
                any_req = 1'b1;
            end
        end
    end

    assign sel_op  = i_op[3*win +: 3];
    assign sel_in1 = i_in1[DATA_W*win +: DATA_W];
    assign sel_in2 = i_in2[DATA_W*win +: DATA_W];
    assign bad     = (sel_op == 3'd0) || (sel_op > 3'd5) ||
                     (((sel_op == 3'd4) || (sel_op == 3'd5)) && (sel_in1 == '0));

    always_comb begin
        state_next = (state == IDLE)  ? (any_req ? ISSUE : IDLE) :
                     (state == ISSUE) ? WAIT :
                     (state == WAIT)  ? DONE : IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_gnt  <= IW'(N_CORES - 1);
            win_q     <= '0;
            err_q     <= 1'b0;
            o_gnt     <= '0;
            o_done    <= '0;
            o_result  <= '0;
            o_z       <= 1'b0;
            o_err     <= 1'b0;
            o_alu_op  <= 3'd0;
            o_alu_in1 <= '0;
            o_alu_in2 <= '0;
        end else begin
            o_gnt    <= '0;
            o_done   <= '0;
            o_alu_op <= 3'd0;
            if (state == IDLE && any_req) begin
                last_gnt  <= win;
                win_q     <= win;
                err_q     <= bad;
                o_gnt     <= ONE << win;
                // A screened op is never shown to the ALU, so it keeps its value and never sees /0.
                o_alu_op  <= bad ? 3'd0 : sel_op;
                o_alu_in1 <= sel_in1;
                o_alu_in2 <= sel_in2;
            end
            if (state == WAIT) begin
                o_result <= err_q ? '0 : i_alu_out;
                o_z      <= !err_q && (i_alu_out == '0);
                o_err    <= err_q;
                o_done   <= ONE << win_q;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural registered ALU
module tb_alu_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [3:0]  i_req = '0;
    logic [11:0] i_op  = '0;
    logic [63:0] i_in1 = '0;
    logic [63:0] i_in2 = '0;
    logic [3:0]  o_gnt, o_done;
    logic [15:0] o_result, o_alu_in1, o_alu_in2;
    logic        o_z, o_err;
    logic [2:0]  o_alu_op;
    logic [15:0] alu_out = 16'h0;
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0]  W_OP  [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
    localparam logic [15:0] W_IN1 [4] = '{16'd2, 16'h0100, 16'd5, 16'd5};
    localparam logic [15:0] W_IN2 [4] = '{16'd1, 16'h0100, 16'd17, 16'd17};
    localparam logic [15:0] W_EXP [4] = '{16'hFFFF, 16'h0000, 16'd3, 16'd2};
    localparam logic        W_Z   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [3:0]  RR_EXP [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    alu_arbiter #(.N_CORES(4), .DATA_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_op(i_op),
        .i_in1(i_in1), .i_in2(i_in2), .o_gnt(o_gnt), .o_done(o_done),
        .o_result(o_result), .o_z(o_z), .o_err(o_err), .o_alu_op(o_alu_op),
        .o_alu_in1(o_alu_in1), .o_alu_in2(o_alu_in2), .i_alu_out(alu_out)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        case (o_alu_op)
            3'd1: alu_out <= o_alu_in2 + o_alu_in1;
            3'd2: alu_out <= o_alu_in2 - o_alu_in1;
            3'd3: alu_out <= 16'(o_alu_in2 * o_alu_in1);
            3'd4: alu_out <= (o_alu_in1 != 0) ? o_alu_in2 / o_alu_in1 : 16'hDEAD;
            3'd5: alu_out <= (o_alu_in1 != 0) ? o_alu_in2 % o_alu_in1 : 16'hDEAD;
            default: ;
        endcase
    end

    task automatic set_core(input int k, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        i_op[3*k +: 3]   = op;
        i_in1[16*k +: 16] = a;
        i_in2[16*k +: 16] = b;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_req = '0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({o_gnt, o_done, o_result, o_z, o_err, o_alu_op, o_alu_in1, o_alu_in2} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b done=%b res=%h z=%b err=%b op=%0d in1=%h in2=%h, want all 0",
                     o_gnt, o_done, o_result, o_z, o_err, o_alu_op, o_alu_in1, o_alu_in2);
        end
        set_core(0, 3'd1, 16'd3, 16'd4);
        i_req = 4'b0001;
        @(negedge i_clk);
        n_checks++;
        if (o_gnt !== 4'b0001 || o_alu_op !== 3'd1 || o_alu_in1 !== 16'd3 || o_alu_in2 !== 16'd4) begin
            n_fail++;
            $display("FAIL first_grant: got gnt=%b op=%0d in1=%h in2=%h, want 0001 1 0003 0004", o_gnt, o_alu_op, o_alu_in1, o_alu_in2);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_alu_op !== 3'd0 || o_gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL wait_idle_op: got op=%0d gnt=%b, want 0 0000", o_alu_op, o_gnt);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_done !== 4'b0001 || o_result !== 16'd7 || o_z !== 1'b0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL first_done: got done=%b res=%h z=%b err=%b, want 0001 0007 0 0", o_done, o_result, o_z, o_err);
        end
        i_req = '0;
        @(negedge i_clk);
        n_checks++;
        if (o_done !== 4'b0000 || o_result !== 16'd7) begin
            n_fail++;
            $display("FAIL done_clear: got done=%b res=%h, want 0000 0007", o_done, o_result);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gseen [5];
        int gcyc [5];
        int ng = 0;
        bit seen2 = 1'b0;
        do_reset();
        set_core(0, 3'd1, 16'd1, 16'd1);
        set_core(1, 3'd1, 16'd2, 16'd2);
        set_core(2, 3'd2, 16'd5, 16'd5);
        set_core(3, 3'd3, 16'd3, 16'd3);
        i_req = 4'b1111;
        for (int c = 1; c <= 24; c++) begin
            @(negedge i_clk);
            if (o_gnt != 4'b0000 && ng < 5) begin
                gseen[ng] = o_gnt;
                gcyc[ng]  = c;
                ng++;
            end
            if (o_done == 4'b0100 && !seen2) begin
                seen2 = 1'b1;
                n_checks++;
                if (o_result !== 16'd0 || o_z !== 1'b1 || o_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_sub_zero: got res=%h z=%b err=%b, want 0000 1 0", o_result, o_z, o_err);
                end
            end
        end
        i_req = '0;
        n_checks++;
        if (ng !== 5 || !seen2) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d grants core2_done=%b, want 5 1", ng, seen2);
        end
        for (int j = 0; j < ng; j++) begin
            n_checks++;
            if (gseen[j] !== RR_EXP[j] || gcyc[j] !== 1 + 4*j) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got gnt=%b at cycle %0d, want %b at cycle %0d", j, gseen[j], gcyc[j], RR_EXP[j], 1 + 4*j);
            end
        end
    endtask

    task automatic test_wrap_truncate();
        for (int v = 0; v < 4; v++) begin
            set_core(0, W_OP[v], W_IN1[v], W_IN2[v]);
            i_req = 4'b0001;
            @(negedge i_clk);
            n_checks++;
            if (o_gnt !== 4'b0001 || o_alu_op !== W_OP[v]) begin
                n_fail++;
                $display("FAIL wrap%0d_grant: got gnt=%b op=%0d, want 0001 %0d", v, o_gnt, o_alu_op, W_OP[v]);
            end
            repeat (2) @(negedge i_clk);
            n_checks++;
            if (o_done !== 4'b0001 || o_result !== W_EXP[v] || o_z !== W_Z[v] || o_err !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap%0d_result: got done=%b res=%h z=%b err=%b, want 0001 %h %b 0",
                         v, o_done, o_result, o_z, o_err, W_EXP[v], W_Z[v]);
            end
            i_req = '0;
            @(negedge i_clk);
        end
    endtask

    task automatic test_screening();
        logic [2:0]  sop [2] = '{3'd4, 3'd7};
        logic [15:0] sa  [2] = '{16'd0, 16'd3};
        for (int v = 0; v < 2; v++) begin
            set_core(1, sop[v], sa[v], 16'd9);
            i_req = 4'b0010;
            for (int c = 1; c <= 3; c++) begin
                @(negedge i_clk);
                n_checks++;
                if (o_alu_op !== 3'd0) begin
                    n_fail++;
                    $display("FAIL screen%0d_aluop_c%0d: got %0d, want 0", v, c, o_alu_op);
                end
                if (c == 1) begin
                    n_checks++;
                    if (o_gnt !== 4'b0010) begin
                        n_fail++;
                        $display("FAIL screen%0d_grant: got %b, want 0010", v, o_gnt);
                    end
                end
            end
            n_checks++;
            if (o_done !== 4'b0010 || o_err !== 1'b1 || o_result !== 16'd0 || o_z !== 1'b0) begin
                n_fail++;
                $display("FAIL screen%0d_done: got done=%b err=%b res=%h z=%b, want 0010 1 0000 0", v, o_done, o_err, o_result, o_z);
            end
            i_req = '0;
            @(negedge i_clk);
        end
    endtask

    task automatic test_drop_after_grant();
        set_core(1, 3'd1, 16'd10, 16'd20);
        i_req = 4'b0010;
        @(negedge i_clk);
        n_checks++;
        if (o_gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_grant: got %b, want 0010", o_gnt);
        end
        @(negedge i_clk);
        i_req = '0;
        @(negedge i_clk);
        n_checks++;
        if (o_done !== 4'b0010 || o_result !== 16'd30 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_done: got done=%b res=%h err=%b, want 0010 001e 0", o_done, o_result, o_err);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid_op();
        set_core(2, 3'd1, 16'd1, 16'd1);
        i_req = 4'b0100;
        @(negedge i_clk);
        n_checks++;
        if (o_gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL midrst_grant: got %b, want 0100", o_gnt);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        n_checks++;
        if ({o_gnt, o_done, o_result, o_z, o_err, o_alu_op, o_alu_in1, o_alu_in2} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got gnt=%b done=%b res=%h z=%b err=%b op=%0d, want all 0",
                     o_gnt, o_done, o_result, o_z, o_err, o_alu_op);
        end
        set_core(3, 3'd1, 16'd2, 16'd2);
        set_core(0, 3'd1, 16'd6, 16'd6);
        i_req = 4'b1001;
        @(negedge i_clk);
        n_checks++;
        if (o_gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_regrant: got %b, want 0001", o_gnt);
        end
        repeat (2) @(negedge i_clk);
        n_checks++;
        if (o_done !== 4'b0001 || o_result !== 16'd12) begin
            n_fail++;
            $display("FAIL midrst_done: got done=%b res=%h, want 0001 000c", o_done, o_result);
        end
        i_req = '0;
        @(negedge i_clk);
    endtask

    task automatic test_operand_stability();
        set_core(0, 3'd1, 16'd3, 16'd4);
        i_req = 4'b0001;
        @(negedge i_clk);
        n_checks++;
        if (o_gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL stable_grant: got %b, want 0001", o_gnt);
        end
        set_core(0, 3'd1, 16'd100, 16'd4);
        repeat (2) @(negedge i_clk);
        n_checks++;
        if (o_done !== 4'b0001 || o_result !== 16'd7) begin
            n_fail++;
            $display("FAIL stable_result: got done=%b res=%h, want 0001 0007", o_done, o_result);
        end
        i_req = '0;
        @(negedge i_clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap_truncate();
        test_screening();
        test_drop_after_grant();
        test_reset_mid_op();
        test_operand_stability();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
